// File: rtl/fp_encoder_seq_if.sv
// Handshake and data bundle between the sign-magnitude front end and fp_encoder_seq.
// The requester drives start/S_in/mag_in; the encoder returns busy/done and the S/E/F result.
interface fp_encoder_seq_if;
  logic        start;
  logic        S_in;
  logic [11:0] mag_in;
  logic        busy;
  logic        done;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;

  modport master (output start, S_in, mag_in, input busy, done, S, E, F);
  modport slave  (input start, S_in, mag_in, output busy, done, S, E, F);
endinterface

// File: rtl/fp_encoder_seq.sv
// Sequential 12-bit sign-magnitude to 8-bit float (S/E3/F4) encoder: iterative normalize, then round.
// Define FP_ROUND_EN for round-half-up with carry/saturation; otherwise the significand is truncated.
module fp_encoder_seq (
  input  logic             clk,
  input  logic             rst_n,
  fp_encoder_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;

  state_t      state, state_nxt;
  logic [11:0] m, m_nxt;
  logic [2:0]  e, e_nxt;
  logic        s, s_nxt;
  logic        s_out, s_out_nxt;
  logic [2:0]  e_out, e_out_nxt;
  logic [3:0]  f_out, f_out_nxt;
  logic        done_r, done_nxt;
  logic [3:0]  f_rnd;
  logic [2:0]  e_rnd;

`ifdef FP_ROUND_EN
  logic [4:0] f_inc;

  // A carry out of the significand renormalizes to 1000 and bumps the exponent, unless already at 7.
  always_comb begin
    f_inc = {1'b0, m[10:7]} + 5'd1;
    f_rnd = m[10:7];
    e_rnd = e;
    if (m[6]) begin
      if (!f_inc[4]) begin
        f_rnd = f_inc[3:0];
      end else if (e == 3'd7) begin
        f_rnd = 4'b1111;
      end else begin
        f_rnd = 4'b1000;
        e_rnd = e + 3'd1;
      end
    end
  end
`else
  assign f_rnd = m[10:7];
  assign e_rnd = e;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      e      <= '0;
      s      <= 1'b0;
      s_out  <= 1'b0;
      e_out  <= '0;
      f_out  <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      m      <= m_nxt;
      e      <= e_nxt;
      s      <= s_nxt;
      s_out  <= s_out_nxt;
      e_out  <= e_out_nxt;
      f_out  <= f_out_nxt;
      done_r <= done_nxt;
    end
  end

  // Out-of-range magnitudes (bit 11 set) clamp to the largest legal input so they saturate cleanly.
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    e_nxt     = e;
    s_nxt     = s;
    s_out_nxt = s_out;
    e_out_nxt = e_out;
    f_out_nxt = f_out;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          s_nxt     = bus.S_in;
          e_nxt     = 3'd7;
          m_nxt     = bus.mag_in[11] ? 12'h7FF : bus.mag_in;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (m[11] || m[10] || (e == 3'd0)) begin
          state_nxt = ROUND;
        end else begin
          m_nxt = {m[10:0], 1'b0};
          e_nxt = e - 3'd1;
        end
      end
      ROUND: begin
        s_out_nxt = s;
        e_out_nxt = e_rnd;
        f_out_nxt = f_rnd;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.S    = s_out;
  assign bus.E    = e_out;
  assign bus.F    = f_out;

endmodule

// File: tb/tb_fp_encoder_seq.sv
// Directed scoreboard bench for fp_encoder_seq: expected S/E/F/latency queued at start, checked at done.
// Expectations for rounding cases follow FP_ROUND_EN.
module tb_fp_encoder_seq;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    int         lat;
    int         t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  exp_t sb[$];

  fp_encoder_seq_if bus ();

  fp_encoder_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called on a falling edge; start is seen by the next rising edge, which is latency cycle 0.
  task automatic applyStimulus(input logic s_in, input logic [11:0] mag,
                               input logic es, input logic [2:0] ee,
                               input logic [3:0] ef, input int lat);
    exp_t x;
    x.s   = es;
    x.e   = ee;
    x.f   = ef;
    x.lat = lat;
    x.t0  = cyc + 1;
    sb.push_back(x);
    bus.start  = 1'b1;
    bus.S_in   = s_in;
    bus.mag_in = mag;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t x;
    int   waited = 0;
    while (bus.done !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
    x = sb.pop_front();
    if (bus.done === 1'b1) begin
      chk({tag, " latency"}, cyc - x.t0, x.lat);
      chk({tag, " S"}, {31'd0, bus.S}, {31'd0, x.s});
      chk({tag, " E"}, {29'd0, bus.E}, {29'd0, x.e});
      chk({tag, " F"}, {28'd0, bus.F}, {28'd0, x.f});
      chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    end
  endtask

  initial begin
    int done_seen;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.S_in   = 1'b0;
    bus.mag_in = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset S", {31'd0, bus.S}, 32'd0);
    chk("reset E", {29'd0, bus.E}, 32'd0);
    chk("reset F", {28'd0, bus.F}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(1'b0, 12'h02C, 1'b0, 3'd2, 4'b1011, 7);
    checkOutput("norm_02c");
    @(negedge clk);
    chk("done one cycle", {31'd0, bus.done}, 32'd0);

`ifdef FP_ROUND_EN
    applyStimulus(1'b0, 12'h07C, 1'b0, 3'd4, 4'b1000, 6);
`else
    applyStimulus(1'b0, 12'h07C, 1'b0, 3'd3, 4'b1111, 6);
`endif
    checkOutput("carry_07c");
    @(negedge clk);

    applyStimulus(1'b1, 12'h7FF, 1'b1, 3'd7, 4'b1111, 2);
    checkOutput("sat_7ff");
    @(negedge clk);

    applyStimulus(1'b0, 12'h00D, 1'b0, 3'd0, 4'b1101, 9);
    checkOutput("small_00d");
    @(negedge clk);

    applyStimulus(1'b1, 12'h000, 1'b1, 3'd0, 4'b0000, 9);
    checkOutput("zero_neg");
    @(negedge clk);

`ifdef FP_ROUND_EN
    applyStimulus(1'b0, 12'h0F8, 1'b0, 3'd5, 4'b1000, 5);
`else
    applyStimulus(1'b0, 12'h0F8, 1'b0, 3'd4, 4'b1111, 5);
`endif
    checkOutput("carry_0f8");
    @(negedge clk);

    applyStimulus(1'b0, 12'h800, 1'b0, 3'd7, 4'b1111, 2);
    checkOutput("clamp_800");
    @(negedge clk);

    // Second start issued during the first done cycle.
    applyStimulus(1'b0, 12'h010, 1'b0, 3'd1, 4'b1000, 8);
    checkOutput("b2b_first_010");
    applyStimulus(1'b1, 12'h400, 1'b1, 3'd7, 4'b1000, 2);
    checkOutput("b2b_second_400");
    @(negedge clk);

    applyStimulus(1'b0, 12'h02C, 1'b0, 3'd2, 4'b1011, 7);
    @(negedge clk);
    chk("busy mid norm", {31'd0, bus.busy}, 32'd1);
    bus.start  = 1'b1;
    bus.S_in   = 1'b1;
    bus.mag_in = 12'h7FF;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("ignore_start");
    @(negedge clk);

    $display("[TB] reset abort during NORM");
    bus.start  = 1'b1;
    bus.S_in   = 1'b1;
    bus.mag_in = 12'h00D;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort S", {31'd0, bus.S}, 32'd0);
    chk("abort E", {29'd0, bus.E}, 32'd0);
    chk("abort F", {28'd0, bus.F}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    chk("no done after abort", done_seen, 32'd0);

    applyStimulus(1'b0, 12'h001, 1'b0, 3'd0, 4'b0001, 9);
    checkOutput("after_reset_001");
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
